// File: rtl/vlsu_axi_txn_issuer.sv
// VLSU AXI transaction issuer: one fragment in, one single-beat AR/AW request out, via a 2-entry buffer.
// Optional perf counters are compiled in with `define VLSU_TXN_PERF_CNT_EN.
module vlsu_axi_txn_issuer #(
  parameter int REQ_ID_BITS     = 8,
  parameter int VLSU_ADDR_BITS  = 32,
  parameter int AXI4_ADDR_BITS  = 32,
  parameter int AXI4_ID_BITS    = 4,
  parameter int TXN_CNT_BITS    = 8,
  parameter int SLEN            = 128,
  parameter int MAX_OUTSTANDING = 8,
  localparam int OCW            = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      meta_valid_i,
  output logic                      meta_ready_o,
  input  logic [REQ_ID_BITS-1:0]    meta_req_id_i,
  input  logic                      meta_is_load_i,
  input  logic [VLSU_ADDR_BITS-1:0] meta_seg_base_addr_i,
  input  logic [TXN_CNT_BITS-1:0]   meta_txn_cnt_i,
  output logic                      ax_valid_o,
  input  logic                      ax_ready_i,
  output logic [AXI4_ADDR_BITS-1:0] ax_addr_o,
  output logic [AXI4_ID_BITS-1:0]   ax_id_o,
  output logic [7:0]                ax_len_o,
  output logic [2:0]                ax_size_o,
  output logic [1:0]                ax_burst_o,
  output logic                      ax_is_load_o,
  input  logic                      txn_done_i,
  output logic [OCW-1:0]            outstanding_o,
  output logic                      idle_o
`ifdef VLSU_TXN_PERF_CNT_EN
  ,
  output logic [31:0]               perf_txn_cnt_o,
  output logic [31:0]               perf_stall_cnt_o
`endif
);

  localparam int BYTES = SLEN / 8;
  localparam int SIZE  = $clog2(BYTES);
  localparam logic [OCW-1:0] MAX_OS = OCW'(MAX_OUTSTANDING);

  typedef struct packed {
    logic [AXI4_ADDR_BITS-1:0] addr;
    logic [AXI4_ID_BITS-1:0]   id;
    logic                      is_load;
  } ent_t;

  ent_t       fifo_q [2];
  logic       wr_ptr, rd_ptr;
  logic [1:0] cnt;
  logic       accept, issue;

  logic [AXI4_ADDR_BITS-1:0] base, aligned, offset;
  ent_t                      new_ent;

  // Reset gates ready so nothing is accepted while the block is held in reset.
  assign meta_ready_o = rst_ni && (cnt != 2'd2) && (outstanding_o < MAX_OS);
  assign accept       = meta_valid_i && meta_ready_o;
  assign issue        = ax_valid_o && ax_ready_i;

  // Nibble -> byte address; non-first txns snap to the beat boundary of the segment base.
  assign base    = AXI4_ADDR_BITS'(meta_seg_base_addr_i >> 1);
  assign aligned = base & ~AXI4_ADDR_BITS'(BYTES - 1);
  assign offset  = AXI4_ADDR_BITS'(meta_txn_cnt_i) << SIZE;

  always_comb begin
    new_ent         = '0;
    new_ent.addr    = (meta_txn_cnt_i == '0) ? base : aligned + offset;
    new_ent.id      = meta_req_id_i[AXI4_ID_BITS-1:0];
    new_ent.is_load = meta_is_load_i;
  end

  always_ff @(posedge clk_i) begin
    if (accept) fifo_q[wr_ptr] <= new_ent;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      cnt    <= 2'd0;
    end else begin
      if (accept) wr_ptr <= ~wr_ptr;
      if (issue)  rd_ptr <= ~rd_ptr;
      case ({accept, issue})
        2'b10:   cnt <= cnt + 2'd1;
        2'b01:   cnt <= cnt - 2'd1;
        default: cnt <= cnt;
      endcase
    end
  end

  assign ax_valid_o   = (cnt != 2'd0);
  assign ax_addr_o    = fifo_q[rd_ptr].addr;
  assign ax_id_o      = fifo_q[rd_ptr].id;
  assign ax_is_load_o = fifo_q[rd_ptr].is_load;
  assign ax_len_o     = 8'd0;
  assign ax_size_o    = 3'(SIZE);
  assign ax_burst_o   = 2'b01;

  // Reservation is taken at accept so a full AXI pipeline can never overrun the completion side.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      outstanding_o <= '0;
    end else if (accept && !txn_done_i) begin
      outstanding_o <= outstanding_o + OCW'(1);
    end else if (!accept && txn_done_i && outstanding_o != '0) begin
      outstanding_o <= outstanding_o - OCW'(1);
    end
  end

  assign idle_o = (cnt == 2'd0) && (outstanding_o == '0);

  a_no_done_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(txn_done_i && !accept && outstanding_o == '0));

`ifdef VLSU_TXN_PERF_CNT_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      perf_txn_cnt_o   <= '0;
      perf_stall_cnt_o <= '0;
    end else begin
      if (issue)                         perf_txn_cnt_o   <= perf_txn_cnt_o + 32'd1;
      if (meta_valid_i && !meta_ready_o) perf_stall_cnt_o <= perf_stall_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_vlsu_axi_txn_issuer.sv
// Scoreboard bench for vlsu_axi_txn_issuer: directed corner cases then randomized traffic.
module tb_vlsu_axi_txn_issuer;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        meta_valid_i = 1'b0;
  logic        meta_ready_o;
  logic [7:0]  meta_req_id_i = '0;
  logic        meta_is_load_i = 1'b0;
  logic [31:0] meta_seg_base_addr_i = '0;
  logic [7:0]  meta_txn_cnt_i = '0;
  logic        ax_valid_o;
  logic        ax_ready_i = 1'b0;
  logic [31:0] ax_addr_o;
  logic [3:0]  ax_id_o;
  logic [7:0]  ax_len_o;
  logic [2:0]  ax_size_o;
  logic [1:0]  ax_burst_o;
  logic        ax_is_load_o;
  logic        txn_done_i = 1'b0;
  logic [3:0]  outstanding_o;
  logic        idle_o;
`ifdef VLSU_TXN_PERF_CNT_EN
  logic [31:0] perf_txn_cnt_o, perf_stall_cnt_o;
`endif

  vlsu_axi_txn_issuer dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .meta_valid_i(meta_valid_i), .meta_ready_o(meta_ready_o),
    .meta_req_id_i(meta_req_id_i), .meta_is_load_i(meta_is_load_i),
    .meta_seg_base_addr_i(meta_seg_base_addr_i), .meta_txn_cnt_i(meta_txn_cnt_i),
    .ax_valid_o(ax_valid_o), .ax_ready_i(ax_ready_i), .ax_addr_o(ax_addr_o),
    .ax_id_o(ax_id_o), .ax_len_o(ax_len_o), .ax_size_o(ax_size_o),
    .ax_burst_o(ax_burst_o), .ax_is_load_o(ax_is_load_o),
    .txn_done_i(txn_done_i), .outstanding_o(outstanding_o), .idle_o(idle_o)
`ifdef VLSU_TXN_PERF_CNT_EN
    , .perf_txn_cnt_o(perf_txn_cnt_o), .perf_stall_cnt_o(perf_stall_cnt_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  id;
    logic        ld;
  } exp_t;

  exp_t sb[$];
  int   os_exp = 0;
  int   vectors = 0, errors = 0;
  bit   hold_v = 0;
  exp_t held;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference address: byte base, or beat-aligned base plus index * 16 bytes, mod 2^32.
  function automatic logic [31:0] ref_addr(input logic [31:0] seg, input logic [7:0] tc);
    longint unsigned b, a;
    b = longint'(seg) / 2;
    if (tc == 0) a = b;
    else         a = (b / 16) * 16 + longint'(tc) * 16;
    return a[31:0];
  endfunction

  // Monitor: samples at negedge, between driver updates and the next active edge.
  always @(negedge clk_i) begin
    if (!rst_ni) begin
      sb.delete();
      os_exp = 0;
      hold_v = 0;
      chk("rst_ax_valid", ax_valid_o, 0);
      chk("rst_meta_ready", meta_ready_o, 0);
      chk("rst_outstanding", outstanding_o, 0);
      chk("rst_idle", idle_o, 1);
    end else begin
      chk("meta_ready", meta_ready_o, (sb.size() < 2 && os_exp < 8));
      chk("outstanding", outstanding_o, os_exp);
      chk("idle", idle_o, (sb.size() == 0 && os_exp == 0));
      chk("ax_valid", ax_valid_o, sb.size() != 0);
      if (hold_v) begin
        chk("hold_addr", ax_addr_o, held.addr);
        chk("hold_id", ax_id_o, held.id);
        chk("hold_ld", ax_is_load_o, held.ld);
      end
      if (ax_valid_o) begin
        chk("ax_len", ax_len_o, 0);
        chk("ax_size", ax_size_o, 4);
        chk("ax_burst", ax_burst_o, 1);
      end
      if (ax_valid_o && ax_ready_i) begin
        if (sb.size() == 0) chk("spurious_issue", 1, 0);
        else begin
          exp_t e;
          e = sb.pop_front();
          chk("ax_addr", ax_addr_o, e.addr);
          chk("ax_id", ax_id_o, e.id);
          chk("ax_is_load", ax_is_load_o, e.ld);
        end
      end
      hold_v = ax_valid_o && !ax_ready_i;
      held.addr = ax_addr_o; held.id = ax_id_o; held.ld = ax_is_load_o;
      if (meta_valid_i && meta_ready_o) begin
        exp_t n;
        n.addr = ref_addr(meta_seg_base_addr_i, meta_txn_cnt_i);
        n.id   = meta_req_id_i[3:0];
        n.ld   = meta_is_load_i;
        sb.push_back(n);
        if (!txn_done_i) os_exp++;
      end else if (txn_done_i && os_exp > 0) begin
        os_exp--;
      end
    end
  end

  task automatic send(input logic ld, input logic [31:0] base, input logic [7:0] tc);
    bit acc;
    acc = 0;
    meta_valid_i = 1; meta_is_load_i = ld; meta_seg_base_addr_i = base;
    meta_txn_cnt_i = tc; meta_req_id_i = 8'($urandom);
    for (int i = 0; i < 100 && !acc; i++) begin
      @(negedge clk_i); acc = meta_ready_o;
      @(posedge clk_i); #1;
    end
    meta_valid_i = 0;
    if (!acc) chk("send_timeout", 0, 1);
  endtask

  task automatic drain();
    meta_valid_i = 0; ax_ready_i = 1;
    for (int i = 0; i < 200 && !(os_exp == 0 && sb.size() == 0); i++) begin
      txn_done_i = (os_exp > 0);
      @(posedge clk_i); #1;
    end
    txn_done_i = 0;
    @(negedge clk_i);
    chk("drain_idle", idle_o, 1);
    @(posedge clk_i); #1;
  endtask

  initial begin
    repeat (3) @(posedge clk_i);
    #1 rst_ni = 1;
    @(posedge clk_i); #1;

    // Spec examples: first-txn address and latency, then aligned txn index.
    ax_ready_i = 1;
    send(1, 32'h0000_0106, 8'd0);
    @(negedge clk_i);
    chk("t1_valid", ax_valid_o, 1);
    chk("t1_addr", ax_addr_o, 32'h83);
    chk("t1_is_load", ax_is_load_o, 1);
    @(posedge clk_i); #1;
    send(0, 32'h0000_0106, 8'd2);
    @(negedge clk_i);
    chk("t2_addr", ax_addr_o, 32'hA0);
    chk("t2_is_load", ax_is_load_o, 0);
    @(posedge clk_i); #1;
    drain();

    // Backpressure: two buffered, third refused, then drain in order.
    ax_ready_i = 0;
    send(1, 32'h1000, 8'd0);
    send(0, 32'h2000, 8'd1);
    meta_valid_i = 1; meta_seg_base_addr_i = 32'h3000; meta_txn_cnt_i = 8'd3;
    repeat (3) begin
      @(negedge clk_i); chk("full_ready", meta_ready_o, 0);
      @(posedge clk_i); #1;
    end
    ax_ready_i = 1;
    send(1, 32'h3000, 8'd3);
    drain();

    // Outstanding limit, release by one completion, then accept+done at 3.
    ax_ready_i = 1;
    for (int k = 0; k < 8; k++) send(k[0], 32'($urandom), 8'(k));
    @(negedge clk_i);
    chk("os_full", outstanding_o, 8);
    chk("os_full_ready", meta_ready_o, 0);
    @(posedge clk_i); #1 txn_done_i = 1;
    @(posedge clk_i); #1 txn_done_i = 0;
    @(negedge clk_i);
    chk("os_7", outstanding_o, 7);
    chk("os_7_ready", meta_ready_o, 1);
    @(posedge clk_i); #1 txn_done_i = 1;
    repeat (4) @(posedge clk_i);
    #1 txn_done_i = 1; meta_valid_i = 1; meta_txn_cnt_i = 8'd0;
    @(negedge clk_i);
    chk("os_3_pre", outstanding_o, 3);
    @(posedge clk_i); #1 txn_done_i = 0; meta_valid_i = 0;
    @(negedge clk_i);
    chk("os_3_post", outstanding_o, 3);
    @(posedge clk_i); #1;
    drain();

    // Reset with two buffered entries.
    ax_ready_i = 0;
    send(1, 32'h4444, 8'd0);
    send(1, 32'h5555, 8'd5);
    rst_ni = 0;
    #1;
    chk("mid_rst_valid", ax_valid_o, 0);
    chk("mid_rst_os", outstanding_o, 0);
    chk("mid_rst_idle", idle_o, 1);
    repeat (2) @(posedge clk_i);
    #1 rst_ni = 1;
    @(posedge clk_i); #1;

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      meta_valid_i         = ($urandom_range(0, 99) < 60);
      meta_is_load_i       = 1'($urandom);
      meta_req_id_i        = 8'($urandom);
      meta_seg_base_addr_i = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 255)) : $urandom;
      meta_txn_cnt_i       = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom);
      ax_ready_i           = ($urandom_range(0, 99) < 70);
      txn_done_i           = (os_exp > 0) && ($urandom_range(0, 99) < 45);
      @(posedge clk_i); #1;
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
